// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero completes in one edge and raises div_err.
module seq_divider #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic [2*N-1:0] quotient,
   output logic [N-1:0]   remainder,
   output logic           busy,
   output logic           done,
   output logic           div_err
);

   localparam int CW = $clog2(2*N+1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [N:0]     r_q, r_d;
   logic [2*N-1:0] q_q, q_d;
   logic [N-1:0]   d_q, d_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] quo_q, quo_d;
   logic [N-1:0]   rem_q, rem_d;

   logic [N:0]     r_shift;
   logic [N:0]     r_sub;
   logic           fits;
   logic [N:0]     r_next;
   logic [2*N-1:0] q_next;

   // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
   assign r_shift = {r_q[N-1:0], q_q[2*N-1]};
   assign fits    = (r_shift >= {1'b0, d_q});
   assign r_sub   = r_shift - {1'b0, d_q};
   assign r_next  = fits ? r_sub : r_shift;
   assign q_next  = {q_q[2*N-2:0], fits};

`ifdef DIV_ZERO_FAST_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
`ifdef DIV_ZERO_FAST_EN
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
`ifdef DIV_ZERO_FAST_EN
               if (divisor == '0) begin
                  quo_d   = '1;
                  rem_d   = dividend[N-1:0];
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  r_d     = '0;
                  q_d     = dividend;
                  d_d     = divisor;
                  cnt_d   = CW'(2*N);
                  err_d   = 1'b0;
                  state_d = S_BUSY;
               end
`else
               r_d     = '0;
               q_d     = dividend;
               d_d     = divisor;
               cnt_d   = CW'(2*N);
               state_d = S_BUSY;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            r_d   = r_next;
            q_d   = q_next;
            cnt_d = cnt_q - CW'(1);
            // Results are published only on the final step so they stay stable while iterating.
            if (cnt_q == CW'(1)) begin
               quo_d   = q_next;
               rem_d   = r_next[N-1:0];
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

`ifdef DIV_ZERO_FAST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   assign div_err = err_q;
`else
   assign div_err = 1'b0;
`endif

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign busy      = (state_q == S_BUSY);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: table of operands with hand-computed results,
// an exhaustive identity sweep, and hand-written back-to-back, ignore-start and abort sequences.
module tb_seq_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_err;

   int n_vec = 0;
   int n_err = 0;

   seq_divider #(.N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_err   (div_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issue one operation and sample each cycle #1 after the edge until done or a cycle budget expires.
   task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat, output int busy_cnt);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = 8'($urandom_range(0, 255));
      divisor  = 4'($urandom_range(0, 15));
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: no done within %0d edges (a=%0d b=%0d)", lat, a, b);
      end
   endtask

   initial begin
      int lat, bc, exp_lat, exp_bc, exp_err;
      bit saw_done;

      tbl[0]  = '{8'd200, 4'd7,  8'd28,  4'd4};
      tbl[1]  = '{8'd0,   4'd9,  8'd0,   4'd0};
      tbl[2]  = '{8'd255, 4'd15, 8'd17,  4'd0};
      tbl[3]  = '{8'd255, 4'd1,  8'd255, 4'd0};
      tbl[4]  = '{8'd1,   4'd15, 8'd0,   4'd1};
      tbl[5]  = '{8'd100, 4'd3,  8'd33,  4'd1};
      tbl[6]  = '{8'd15,  4'd0,  8'd255, 4'd15};
      tbl[7]  = '{8'd254, 4'd2,  8'd127, 4'd0};
      tbl[8]  = '{8'd16,  4'd4,  8'd4,   4'd0};
      tbl[9]  = '{8'd128, 4'd11, 8'd11,  4'd7};
      tbl[10] = '{8'd37,  4'd6,  8'd6,   4'd1};
      tbl[11] = '{8'd243, 4'd0,  8'd255, 4'd3};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      check("reset_quotient",  int'(quotient),  0);
      check("reset_remainder", int'(remainder), 0);
      check("reset_busy",      int'(busy),      0);
      check("reset_done",      int'(done),      0);
      check("reset_div_err",   int'(div_err),   0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         exp_lat = (FAST && tbl[i].b == 0) ? 1 : 9;
         exp_bc  = (FAST && tbl[i].b == 0) ? 0 : 8;
         exp_err = (FAST && tbl[i].b == 0) ? 1 : 0;
         run_op(tbl[i].a, tbl[i].b, lat, bc);
         check($sformatf("vec%0d_quotient", i),  int'(quotient),  int'(tbl[i].q));
         check($sformatf("vec%0d_remainder", i), int'(remainder), int'(tbl[i].r));
         check($sformatf("vec%0d_div_err", i),   int'(div_err),   exp_err);
         check($sformatf("vec%0d_latency", i),   lat,             exp_lat);
         check($sformatf("vec%0d_busy_cycles", i), bc,            exp_bc);
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_pulse", i), int'(done),     0);
         check($sformatf("vec%0d_quot_held", i), int'(quotient),  int'(tbl[i].q));
      end

      // Exhaustive sweep against the multiplier identity and integer division.
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            run_op(8'(a), 4'(b), lat, bc);
            check($sformatf("sweep_%0d_%0d_identity", a, b),
                  int'(quotient) * b + int'(remainder), a);
            check($sformatf("sweep_%0d_%0d_rem_lt_div", a, b), int'(remainder < 4'(b)), 1);
            check($sformatf("sweep_%0d_%0d_quotient", a, b), int'(quotient), a / b);
         end
      end
      @(posedge clk); #1;

      // Back-to-back: second start held during the DONE cycle of the first.
      run_op(8'd0, 4'd9, lat, bc);
      check("b2b_first_quotient",  int'(quotient),  0);
      check("b2b_first_remainder", int'(remainder), 0);
      start    = 1'b1;
      dividend = 8'd255;
      divisor  = 4'd15;
      @(posedge clk); #1;
      start    = 1'b0;
      check("b2b_no_idle_busy",  int'(busy), 1);
      check("b2b_done_dropped",  int'(done), 0);
      check("b2b_quot_held_busy", int'(quotient), 0);
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("b2b_second_latency",   lat,              9);
      check("b2b_second_quotient",  int'(quotient),  17);
      check("b2b_second_remainder", int'(remainder), 0);
      @(posedge clk); #1;

      // start pulsed in BUSY is ignored.
      @(negedge clk);
      start = 1'b1; dividend = 8'd100; divisor = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         if (lat == 3) begin
            start = 1'b1; dividend = 8'd50; divisor = 4'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check("ignore_latency",   lat,              9);
      check("ignore_quotient",  int'(quotient),  33);
      check("ignore_remainder", int'(remainder), 1);
      @(posedge clk); #1;
      check("ignore_back_idle", int'(busy | done), 0);

      // Reset in cycle 4 of BUSY aborts with no done pulse.
      @(negedge clk);
      start = 1'b1; dividend = 8'd200; divisor = 4'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("abort_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("abort_quotient",  int'(quotient),  0);
      check("abort_remainder", int'(remainder), 0);
      check("abort_busy",      int'(busy),      0);
      check("abort_done",      int'(done),      0);
      check("abort_div_err",   int'(div_err),   0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      check("abort_no_done_after", int'(saw_done), 0);
      run_op(8'd77, 4'd8, lat, bc);
      check("after_abort_latency",   lat,             9);
      check("after_abort_quotient",  int'(quotient),  9);
      check("after_abort_remainder", int'(remainder), 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
